// File: rtl/frame_ram_writer_pkg.sv
// Frame geometry shared by the frame RAM writer and the VGA read path.
// Holds the default image size, derived byte counts and the writer FSM states.
package frame_geom_pkg;

   localparam int DEF_IMG_W     = 128;
   localparam int DEF_IMG_H     = 128;
   localparam int DEF_ADDR_W    = 11;
   localparam int BYTES_PER_ROW = DEF_IMG_W / 8;
   localparam int FRAME_BYTES   = DEF_IMG_W * DEF_IMG_H / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/frame_ram_writer_if.sv
// Pixel stream in, RAM write port out.
// master = pixel source / RAM side, slave = the frame RAM writer.
interface frame_ram_writer_if
   import frame_geom_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;

   modport master (
      output pix_in,
      output pix_valid,
      input  pix_ready,
      input  ram_we,
      input  ram_addr,
      input  ram_wdata
   );

   modport slave (
      input  pix_in,
      input  pix_valid,
      output pix_ready,
      output ram_we,
      output ram_addr,
      output ram_wdata
   );

endinterface

// File: rtl/frame_ram_writer_pixel_packer.sv
// Assembles 8 serial pixels into one byte; bit k holds pixel x = 8n + k.
// byte_data is the byte including the pixel being loaded this cycle, so the
// caller can capture the complete byte on the same edge as the 8th load.
module pixel_packer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  logic       pix,
   input  logic [2:0] bit_idx,
   output logic [7:0] byte_data,
   output logic       byte_full
);

   logic [7:0] pack_reg;
   logic [7:0] pack_next;

   // Per-bit merge of the incoming pixel into the assembly register.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign pack_next[gi] = (load && (bit_idx == 3'(gi))) ? pix : pack_reg[gi];
      end
   endgenerate

   assign byte_data = pack_next;
   assign byte_full = load && (bit_idx == 3'd7);

   // Assembly register; emptied once a byte has been handed off or a frame starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_reg <= '0;
      end else if (clear || byte_full) begin
         pack_reg <= '0;
      end else begin
         pack_reg <= pack_next;
      end
   end

endmodule

// File: rtl/frame_ram_writer.sv
// Frame RAM writer: fills a 1-bpp frame buffer from a serial pixel stream,
// packing 8 pixels per byte and issuing one RAM write per byte.
// Optional feature macro: FRAME_WRITER_CHECKSUM_EN adds frame_xsum, the
// running XOR of all bytes written in the current frame.
module frame_ram_writer
   import frame_geom_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   frame_ram_writer_if.slave bus,
   output logic              busy,
   output logic              frame_done
`ifdef FRAME_WRITER_CHECKSUM_EN
   ,
   output logic [7:0]        frame_xsum
`endif
);

   localparam int XW        = $clog2(IMG_W);
   localparam int YW        = $clog2(IMG_H);
   localparam int ROW_BYTES = IMG_W / 8;

   state_t            state_reg;
   state_t            state_next;
   logic [XW-1:0]     x_reg;
   logic [YW-1:0]     y_reg;
   logic              accept;
   logic              start_acc;
   logic              pix_ready;
   logic              last_pix;
   logic              byte_full;
   logic [7:0]        byte_data;
   logic [ADDR_W-1:0] byte_addr;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        wdata_reg;

   assign last_pix  = (x_reg == XW'(IMG_W - 1)) && (y_reg == YW'(IMG_H - 1));
   // Byte address of the pixel being accepted, taken before the counters advance.
   assign byte_addr = ADDR_W'(y_reg) * ADDR_W'(ROW_BYTES) + ADDR_W'(x_reg >> 3);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state and state-decoded outputs; start is only honoured in IDLE.
   always_comb begin
      state_next = state_reg;
      pix_ready  = 1'b0;
      accept     = 1'b0;
      start_acc  = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               start_acc  = 1'b1;
               state_next = FILL;
            end
         end
         FILL: begin
            pix_ready = 1'b1;
            accept    = bus.pix_valid;
            if (bus.pix_valid && last_pix) begin
               state_next = LAST;
            end
         end
         LAST: begin
            state_next = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   // Raster position counters: x runs across the line, y steps on line wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (start_acc || (state_reg == DONE)) begin
         x_reg <= '0;
         y_reg <= '0;
      end else if (accept) begin
         if (x_reg == XW'(IMG_W - 1)) begin
            x_reg <= '0;
            y_reg <= (y_reg == YW'(IMG_H - 1)) ? '0 : y_reg + 1'b1;
         end else begin
            x_reg <= x_reg + 1'b1;
         end
      end
   end

   pixel_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_acc),
      .load      (accept),
      .pix       (bus.pix_in),
      .bit_idx   (x_reg[2:0]),
      .byte_data (byte_data),
      .byte_full (byte_full)
   );

   // RAM write registers: strobe for one cycle per byte, address/data hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         we_reg <= byte_full;
         if (byte_full) begin
            addr_reg  <= byte_addr;
            wdata_reg <= byte_data;
         end
      end
   end

   assign bus.pix_ready = pix_ready;
   assign bus.ram_we    = we_reg;
   assign bus.ram_addr  = addr_reg;
   assign bus.ram_wdata = wdata_reg;

`ifdef FRAME_WRITER_CHECKSUM_EN
   logic [7:0] xsum_reg;

   // Running XOR of written bytes, updated on the same edge the write is registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xsum_reg <= '0;
      end else if (start_acc) begin
         xsum_reg <= '0;
      end else if (byte_full) begin
         xsum_reg <= xsum_reg ^ byte_data;
      end
   end

   assign frame_xsum = xsum_reg;
`endif

endmodule

// File: tb/tb_frame_ram_writer.sv
// Testbench for frame_ram_writer: drives pixel frames, predicts every RAM write
// from the image (byte b = pixels 8b..8b+7, bit k = pixel 8b+k) and checks
// each write, the frame image, timing and the abuse cases.
module tb_frame_ram_writer;

   localparam int W    = 128;
   localparam int H    = 128;
   localparam int NPIX = W * H;
   localparam int NB   = NPIX / 8;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic frame_done;
`ifdef FRAME_WRITER_CHECKSUM_EN
   logic [7:0] frame_xsum;
`endif

   frame_ram_writer_if #(.ADDR_W(11)) bus ();

   frame_ram_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef FRAME_WRITER_CHECKSUM_EN
      ,
      .frame_xsum (frame_xsum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         addr;
      logic [7:0] data;
   } wr_t;

   int         tests = 0;
   int         fails = 0;
   int         cycle = 0;
   bit         img [NPIX];
   logic [7:0] ref_mem [NB];
   logic [7:0] dut_mem [NB];
   logic [7:0] ref_xsum;
   wr_t        exp_q [$];
   int         wr_count, done_count, nz_count, nz_addr;
   logic [7:0] nz_data;
   int         first_addr, last_addr;
   logic [7:0] first_data;
   int         last_we_cycle, prev_we_cycle;
   bit         have_prev, check_spacing;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // Reference: byte b collects pixels 8b..8b+7 in raster order, written to address b.
   task automatic build_model();
      logic [7:0] b8;
      exp_q.delete();
      ref_xsum = 8'h00;
      for (int b = 0; b < NB; b++) begin
         b8 = 8'h00;
         for (int k = 0; k < 8; k++) b8[k] = img[8*b + k];
         ref_mem[b] = b8;
         ref_xsum   = ref_xsum ^ b8;
         exp_q.push_back('{addr: b, data: b8});
      end
   endtask

   task automatic set_image_bytes(input int b, input logic [7:0] v);
      for (int k = 0; k < 8; k++) img[8*b + k] = v[k];
   endtask

   // Compare process: every write against the queue, frame_done latency, write spacing.
   always @(negedge clk) begin
      wr_t e;
      if (rst === 1'b0) begin
         if (bus.ram_we === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
               check("ram_wdata", 32'(bus.ram_wdata), 32'(e.data));
            end
            dut_mem[bus.ram_addr] = bus.ram_wdata;
            if (first_addr < 0) begin
               first_addr = int'(bus.ram_addr);
               first_data = bus.ram_wdata;
            end
            last_addr = int'(bus.ram_addr);
            if (bus.ram_wdata != 8'h00) begin
               nz_count++;
               nz_addr = int'(bus.ram_addr);
               nz_data = bus.ram_wdata;
            end
            if (check_spacing && have_prev) check("write_spacing", 32'(cycle - prev_we_cycle), 32'd8);
            prev_we_cycle = cycle;
            have_prev     = 1'b1;
            last_we_cycle = cycle;
            wr_count++;
         end
         if (frame_done === 1'b1) begin
            done_count++;
            check("done_latency", 32'(cycle), 32'(last_we_cycle + 1));
         end
      end
   end

   task automatic run_frame(input bit throttle, input bit abuse, input string tag);
      int  idx, budget, n, errs;
      bit  abused;
      build_model();
      wr_count = 0; done_count = 0; nz_count = 0; nz_addr = -1; nz_data = 8'h00;
      first_addr = -1; first_data = 8'h00; last_addr = -1;
      have_prev = 1'b0; check_spacing = !throttle; abused = 1'b0;
      for (int b = 0; b < NB; b++) dut_mem[b] = 8'hxx;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
`ifdef FRAME_WRITER_CHECKSUM_EN
      check("xsum_cleared", 32'(frame_xsum), 32'd0);
`endif
      idx = 0; budget = 0;
      while (idx < NPIX && budget < 60000) begin
         bus.pix_valid = throttle ? ($urandom_range(0, 7) != 0) : 1'b1;
         bus.pix_in    = bus.pix_valid ? img[idx] : 1'($urandom_range(0, 1));
         start         = 1'b0;
         if (abuse && !abused && idx == 5000) begin
            start  = 1'b1;
            abused = 1'b1;
         end
         if (bus.pix_valid && bus.pix_ready) idx++;
         @(negedge clk);
         budget++;
      end
      start = 1'b0; bus.pix_valid = 1'b0;
      check("all_pixels_accepted", 32'(idx), 32'(NPIX));
      n = 0;
      while (frame_done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_seen", 32'(frame_done), 32'd1);
      if (abuse) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_count", 32'(done_count), 32'd1);
      check("write_count", 32'(wr_count), 32'(NB));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      errs = 0;
      for (int b = 0; b < NB; b++) if (dut_mem[b] !== ref_mem[b]) errs++;
      check("ram_image", 32'(errs), 32'd0);
`ifdef FRAME_WRITER_CHECKSUM_EN
      check("xsum_final", 32'(frame_xsum), 32'(ref_xsum));
`endif
      repeat (3) @(negedge clk);
      check("stays_idle", 32'(busy), 32'd0);
      $display("[TB] frame %s: %0d writes, first addr %0d data %0h, last addr %0d", tag, wr_count,
               first_addr, first_data, last_addr);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
      check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
      check({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
      check({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
`ifdef FRAME_WRITER_CHECKSUM_EN
      check({tag, "_xsum"}, 32'(frame_xsum), 32'd0);
`endif
   endtask

   initial begin
      int acc, budget;
      rst = 1'b1; start = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;

      // Reset after 13 accepted pixels: byte 0 (all ones) is written, the rest is dropped.
      for (int i = 0; i < NPIX; i++) img[i] = 1'b1;
      exp_q.delete();
      exp_q.push_back('{addr: 0, data: 8'hFF});
      wr_count = 0; first_addr = -1; have_prev = 1'b0; check_spacing = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      acc = 0; budget = 0;
      while (acc < 13 && budget < 100) begin
         bus.pix_valid = 1'b1; bus.pix_in = 1'b1;
         if (bus.pix_ready) acc++;
         @(negedge clk);
         budget++;
      end
      bus.pix_valid = 1'b0;
      check("partial_accepts", 32'(acc), 32'd13);
      check("partial_byte_written", 32'(wr_count), 32'd1);
      check("partial_wdata_before_reset", 32'(bus.ram_wdata), 32'hFF);
      #2 rst = 1'b1;
      #1 check_outputs_zero("async_reset");
      check("partial_queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset mid-frame: %0d write(s) before reset", wr_count);

      // pix_valid while idle: never accepted, never written.
      for (int i = 0; i < 20; i++) begin
         bus.pix_valid = 1'b1;
         bus.pix_in    = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("idle_pix_ready", 32'(bus.pix_ready), 32'd0);
         check("idle_ram_we", 32'(bus.ram_we), 32'd0);
      end
      bus.pix_valid = 1'b0;
      $display("[TB] idle pixels: 20 offered, writes seen %0d", wr_count - 1);

      // Alternating 1,0 pixels, full throughput, start pulsed mid-frame and during DONE.
      for (int i = 0; i < NPIX; i++) img[i] = (i % 2 == 0);
      run_frame(1'b0, 1'b1, "alternating");
      check("alt_first_addr", 32'(first_addr), 32'd0);
      check("alt_first_data", 32'(first_data), 32'h55);
      check("alt_last_addr", 32'(last_addr), 32'd2047);
      check("alt_ref_byte", 32'(ref_mem[100]), 32'h55);

      // Bit order: only pixel (x=3, y=1) lit.
      for (int i = 0; i < NPIX; i++) img[i] = 1'b0;
      img[1*W + 3] = 1'b1;
      run_frame(1'b0, 1'b0, "single_pixel");
      check("bitorder_nz_count", 32'(nz_count), 32'd1);
      check("bitorder_addr", 32'(nz_addr), 32'd16);
      check("bitorder_data", 32'(nz_data), 32'h08);

      // Throttled random image with start pulsed while busy.
      for (int i = 0; i < NPIX; i++) img[i] = 1'($urandom_range(0, 1));
      run_frame(1'b1, 1'b1, "throttled_random");

`ifdef FRAME_WRITER_CHECKSUM_EN
      for (int b = 0; b < NB; b++) set_image_bytes(b, (b % 2 == 0) ? 8'hFF : 8'h0F);
      run_frame(1'b0, 1'b0, "xsum_ff_0f");
      check("xsum_ff_0f", 32'(frame_xsum), 32'h00);
      for (int b = 0; b < NB; b++) set_image_bytes(b, 8'h00);
      set_image_bytes(5, 8'hA5);
      run_frame(1'b0, 1'b0, "xsum_a5");
      check("xsum_a5", 32'(frame_xsum), 32'hA5);
      check("xsum_a5_addr", 32'(nz_addr), 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
